// File: rtl/slow_frame_receiver_pkg.sv
// Shared definitions for the slow serial link.
//   payload_t      : 128-bit frame payload, byte k at bits [8k+7:8k]
//   K28_5          : decoded value of the frame-start comma
//   N_PAYLOAD_BYTES: payload bytes per frame
//   frame_state_t  : framing states shared by transmitter and receiver
package slow_frame_receiver_pkg;

   localparam int unsigned N_PAYLOAD_BYTES = 16;
   localparam logic [7:0]  K28_5           = 8'hBC;

   typedef logic [N_PAYLOAD_BYTES*8-1:0] payload_t;

   typedef enum logic [1:0] {
      HUNT    = 2'd0,
      PAYLOAD = 2'd1,
      CHECK   = 2'd2
   } frame_state_t;

endpackage

// File: rtl/slow_frame_receiver.sv
// Receive-side deframer for the slow serial link.
// Consumes the decoded word stream of the 10b/8b CDR, reassembles a
// comma-delimited frame of N_BYTES payload bytes followed by an XOR
// checksum byte, and publishes each good frame.
// Ports:
//   clk           : system clock
//   reset         : asynchronous, active-high reset
//   word_tick_i   : one-cycle strobe; data_i/comma_i/error_i valid with it
//   data_i        : decoded byte
//   comma_i       : decoded word is a K character
//   error_i       : code or disparity error on this word
//   payload_o     : last good payload (byte k at bits [8k+7:8k])
//   frame_tick_o  : one-cycle pulse when payload_o has been updated
//   frame_error_o : one-cycle pulse on frame abort or checksum failure
//   locked_o      : LOCK_COUNT consecutive good frames since last error
module slow_frame_receiver
   import slow_frame_receiver_pkg::*;
#(
   parameter int unsigned N_BYTES      = N_PAYLOAD_BYTES,
   parameter logic [7:0]  COMMA_CODE   = K28_5,
   parameter int unsigned LOCK_COUNT   = 2,
   parameter int unsigned WORD_TIMEOUT = 10000
) (
   input  logic       clk,
   input  logic       reset,
   input  logic       word_tick_i,
   input  logic [7:0] data_i,
   input  logic       comma_i,
   input  logic       error_i,
   output payload_t   payload_o,
   output logic       frame_tick_o,
   output logic       frame_error_o,
   output logic       locked_o
);

   localparam int unsigned BCW = (N_BYTES > 1) ? $clog2(N_BYTES) : 1;
   localparam int unsigned TW  = $clog2(WORD_TIMEOUT + 1);
   localparam int unsigned GW  = $clog2(LOCK_COUNT + 1);

   frame_state_t   state;
   logic [BCW-1:0] byte_cnt;
   logic [7:0]     acc;
   payload_t       shadow;
   logic [TW-1:0]  to_cnt;
   logic [GW-1:0]  good_cnt;
   logic [GW-1:0]  good_next;

   logic valid_comma;
   logic data_word;
   logic timeout_hit;
   logic good_frame;
   logic bad_word;
   logic frame_err;

   always_comb begin
      valid_comma = comma_i && (data_i == COMMA_CODE) && !error_i;
      data_word   = !comma_i && !error_i;
      // Fires on the idle cycle at which the counter would reach WORD_TIMEOUT.
      timeout_hit = (state != HUNT) && !word_tick_i && (to_cnt == TW'(WORD_TIMEOUT - 1));
      good_frame  = word_tick_i && (state == CHECK) && data_word && (data_i == acc);
      // Any non-data word in PAYLOAD is an error, including a resync comma.
      bad_word    = word_tick_i &&
                    (((state == PAYLOAD) && !data_word) ||
                     ((state == CHECK) && !(data_word && (data_i == acc))));
      frame_err   = bad_word || timeout_hit;
   end

   always_comb begin
      good_next = good_cnt;
      if (frame_err) begin
         good_next = '0;
      end else if (good_frame && (good_cnt != GW'(LOCK_COUNT))) begin
         good_next = good_cnt + 1'b1;
      end
   end

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state         <= HUNT;
         byte_cnt      <= '0;
         acc           <= '0;
         shadow        <= '0;
         to_cnt        <= '0;
         good_cnt      <= '0;
         payload_o     <= '0;
         frame_tick_o  <= 1'b0;
         frame_error_o <= 1'b0;
         locked_o      <= 1'b0;
      end else begin
         frame_tick_o  <= good_frame;
         frame_error_o <= frame_err;
         good_cnt      <= good_next;
         locked_o      <= (good_next == GW'(LOCK_COUNT));

         if ((state == HUNT) || word_tick_i || timeout_hit) begin
            to_cnt <= '0;
         end else begin
            to_cnt <= to_cnt + 1'b1;
         end

         if (timeout_hit) begin
            state <= HUNT;
         end else if (word_tick_i) begin
            case (state)
               HUNT: begin
                  if (valid_comma) begin
                     state    <= PAYLOAD;
                     byte_cnt <= '0;
                     acc      <= '0;
                  end
               end
               PAYLOAD: begin
                  if (data_word) begin
                     shadow[{byte_cnt, 3'b000} +: 8] <= data_i;
                     acc <= acc ^ data_i;
                     if (byte_cnt == BCW'(N_BYTES - 1)) begin
                        state <= CHECK;
                     end else begin
                        byte_cnt <= byte_cnt + 1'b1;
                     end
                  end else if (valid_comma) begin
                     byte_cnt <= '0;
                     acc      <= '0;
                  end else begin
                     state <= HUNT;
                  end
               end
               CHECK: begin
                  if (good_frame) begin
                     payload_o <= shadow;
                  end
                  state <= HUNT;
               end
               default: state <= HUNT;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_slow_frame_receiver.sv
module tb_slow_frame_receiver;
   import slow_frame_receiver_pkg::*;

   localparam int WT = 10000;
   localparam int LC = 2;
   localparam int NB = 16;

   logic       clk = 1'b0;
   logic       reset = 1'b1;
   logic       word_tick_i = 1'b0;
   logic [7:0] data_i = '0;
   logic       comma_i = 1'b0;
   logic       error_i = 1'b0;
   payload_t   payload_o;
   logic       frame_tick_o;
   logic       frame_error_o;
   logic       locked_o;

   slow_frame_receiver #(
      .N_BYTES(NB),
      .COMMA_CODE(8'hBC),
      .LOCK_COUNT(LC),
      .WORD_TIMEOUT(WT)
   ) dut (
      .clk(clk),
      .reset(reset),
      .word_tick_i(word_tick_i),
      .data_i(data_i),
      .comma_i(comma_i),
      .error_i(error_i),
      .payload_o(payload_o),
      .frame_tick_o(frame_tick_o),
      .frame_error_o(frame_error_o),
      .locked_o(locked_o)
   );

   always #5 clk = ~clk;

   int cyc = 0;
   always @(posedge clk) cyc <= cyc + 1;

   int checks = 0;
   int errors = 0;

   typedef struct {
      bit       is_err;
      int       at;
      payload_t pl;
      bit       lk;
   } ev_t;
   ev_t expq[$];

   // Reference model: 0 = waiting for comma, 1 = collecting bytes, 2 = awaiting checksum
   int         m_mode = 0;
   logic [7:0] m_bytes[$];
   int         m_last = 0;
   int         m_good = 0;

   function automatic void m_error(input int at);
      ev_t ev;
      m_good    = 0;
      ev.is_err = 1'b1;
      ev.at     = at;
      ev.pl     = '0;
      ev.lk     = 1'b0;
      expq.push_back(ev);
      m_mode = 0;
   endfunction

   // No ticks occur before cycle n: predict a timeout abort if the gap is too long.
   function automatic void m_advance(input int n);
      if (m_mode != 0 && (n - m_last) > WT) m_error(m_last + WT);
   endfunction

   function automatic void m_word(input int n, input bit k, input logic [7:0] d, input bit e);
      ev_t        ev;
      logic [7:0] sum;
      m_advance(n);
      m_last = n;
      if (m_mode == 0) begin
         if (k && d == 8'hBC && !e) begin
            m_mode = 1;
            m_bytes.delete();
         end
      end else if (m_mode == 1) begin
         if (!k && !e) begin
            m_bytes.push_back(d);
            if (m_bytes.size() == NB) m_mode = 2;
         end else if (k && d == 8'hBC && !e) begin
            m_error(n);
            m_mode = 1;
            m_bytes.delete();
         end else begin
            m_error(n);
         end
      end else begin
         sum = '0;
         foreach (m_bytes[i]) sum = sum ^ m_bytes[i];
         if (!k && !e && d == sum) begin
            ev.pl = '0;
            for (int i = 0; i < NB; i++) ev.pl[8*i +: 8] = m_bytes[i];
            if (m_good < LC) m_good++;
            ev.is_err = 1'b0;
            ev.at     = n;
            ev.lk     = (m_good == LC);
            expq.push_back(ev);
         end else begin
            m_error(n);
         end
         m_mode = 0;
      end
   endfunction

   task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s cycle %0d: got %h expected %h", name, cyc, act, exp);
      end
   endtask

   // Monitor: pops expected events when the DUT pulses, tracks expected levels.
   payload_t mon_payload = '0;
   bit       mon_locked = 1'b0;

   always @(negedge clk) begin
      ev_t ev;
      if (reset) begin
         mon_payload = '0;
         mon_locked  = 1'b0;
      end else begin
         while (expq.size() > 0 && expq[0].at < cyc) begin
            ev = expq.pop_front();
            checks++;
            errors++;
            $display("FAIL missing_event cycle %0d: got no pulse, expected %s", ev.at,
                     ev.is_err ? "error pulse" : "frame tick");
            if (!ev.is_err) mon_payload = ev.pl;
            mon_locked = ev.lk;
         end
         chk("tick_error_exclusive", {127'b0, frame_tick_o && frame_error_o}, '0);
         if (frame_tick_o || frame_error_o) begin
            if (expq.size() > 0 && expq[0].at == cyc) begin
               ev = expq.pop_front();
               chk("event_is_error", {127'b0, frame_error_o}, {127'b0, ev.is_err});
               if (!ev.is_err) mon_payload = ev.pl;
               mon_locked = ev.lk;
            end else begin
               checks++;
               errors++;
               $display("FAIL unexpected_event cycle %0d: got tick=%b err=%b, expected no pulse",
                        cyc, frame_tick_o, frame_error_o);
            end
         end
         chk("payload", payload_o, mon_payload);
         chk("locked", {127'b0, locked_o}, {127'b0, mon_locked});
      end
   end

   // Drive one word after `gap` idle cycles; assumes entry just after a posedge.
   task automatic send(input int gap, input bit k, input logic [7:0] d, input bit e);
      m_word(cyc + gap + 1, k, d, e);
      repeat (gap) @(posedge clk);
      #1;
      word_tick_i = 1'b1;
      comma_i     = k;
      data_i      = d;
      error_i     = e;
      @(posedge clk);
      #1;
      word_tick_i = 1'b0;
      data_i      = 8'($urandom);
      comma_i     = 1'($urandom);
      error_i     = 1'($urandom);
   endtask

   task automatic idle(input int g);
      m_advance(cyc + g + 1);
      repeat (g) @(posedge clk);
      #1;
   endtask

   task automatic send_frame(input logic [7:0] seed, input int gap);
      logic [7:0] sum;
      sum = '0;
      send(gap, 1'b1, 8'hBC, 1'b0);
      for (int i = 0; i < NB; i++) begin
         send(gap, 1'b0, seed + 8'(i), 1'b0);
         sum = sum ^ (seed + 8'(i));
      end
      send(gap, 1'b0, sum, 1'b0);
   endtask

   initial begin
      logic [7:0] d;
      logic [7:0] sum;
      int         r;

      #2;
      chk("reset_payload", payload_o, '0);
      chk("reset_tick", {127'b0, frame_tick_o}, '0);
      chk("reset_error", {127'b0, frame_error_o}, '0);
      chk("reset_locked", {127'b0, locked_o}, '0);
      @(posedge clk);
      #1;
      reset = 1'b0;
      idle(3);

      // Good frame 0x00..0x0F, checksum 0x00
      send_frame(8'h00, 0);
      idle(2);
      chk("good_payload", payload_o, 128'h0F0E0D0C0B0A09080706050403020100);

      // Bad checksum
      send(1, 1'b1, 8'hBC, 1'b0);
      for (int i = 0; i < NB; i++) send(0, 1'b0, 8'(i), 1'b0);
      send(0, 1'b0, 8'h55, 1'b0);
      idle(2);
      chk("badsum_payload_kept", payload_o, 128'h0F0E0D0C0B0A09080706050403020100);
      chk("badsum_locked", {127'b0, locked_o}, '0);

      // Mid-frame comma resynchronises
      send(0, 1'b1, 8'hBC, 1'b0);
      for (int i = 0; i < 5; i++) send(1, 1'b0, 8'(8'h30 + i), 1'b0);
      send(0, 1'b1, 8'hBC, 1'b0);
      for (int i = 0; i < NB; i++) send(0, 1'b0, 8'hA5, 1'b0);
      send(0, 1'b0, 8'h00, 1'b0);
      idle(2);
      chk("resync_payload", payload_o, {16{8'hA5}});

      // Code error on byte 7, trailing bytes ignored
      send(0, 1'b1, 8'hBC, 1'b0);
      for (int i = 0; i < NB; i++) send(0, 1'b0, 8'(8'h40 + i), i == 7);
      send(0, 1'b0, 8'h00, 1'b0);
      idle(2);
      chk("codeerr_locked", {127'b0, locked_o}, '0);

      // Two back-to-back good frames reach lock
      send_frame(8'h10, 0);
      chk("lock_after_first", {127'b0, locked_o}, '0);
      send_frame(8'h20, 0);
      chk("lock_after_second", {127'b0, locked_o}, 128'd1);
      chk("b2b_payload", payload_o, 128'h2F2E2D2C2B2A29282726252423222120);

      // Timeout: comma plus 3 bytes then silence
      send(0, 1'b1, 8'hBC, 1'b0);
      for (int i = 0; i < 3; i++) send(0, 1'b0, 8'(8'h70 + i), 1'b0);
      idle(WT + 10);
      chk("timeout_locked", {127'b0, locked_o}, '0);

      // Relock, then asynchronous reset mid-frame
      send_frame(8'h80, 1);
      send_frame(8'h90, 0);
      send(0, 1'b1, 8'hBC, 1'b0);
      for (int i = 0; i < 5; i++) send(0, 1'b0, 8'($urandom), 1'b0);
      #3;
      reset = 1'b1;
      #1;
      chk("async_reset_payload", payload_o, '0);
      chk("async_reset_tick", {127'b0, frame_tick_o}, '0);
      chk("async_reset_error", {127'b0, frame_error_o}, '0);
      chk("async_reset_locked", {127'b0, locked_o}, '0);
      m_mode = 0;
      m_good = 0;
      m_bytes.delete();
      @(posedge clk);
      @(posedge clk);
      #1;
      reset = 1'b0;
      m_last = cyc;
      for (int i = 0; i < 6; i++) send(0, 1'b0, 8'(8'hC0 + i), 1'b0);
      send_frame(8'hD0, 0);
      idle(2);
      chk("post_reset_payload", payload_o, 128'hDFDEDDDCDBDAD9D8D7D6D5D4D3D2D1D0);

      // Randomised traffic with occasional corruption
      for (int f = 0; f < 40; f++) begin
         if ($urandom_range(0, 4) == 0) begin
            for (int j = 0; j < 3; j++) begin
               d = 8'($urandom);
               if (d == 8'hBC) d = 8'h1C;
               send($urandom_range(0, 2), 1'($urandom), d, 1'b0);
            end
         end
         send($urandom_range(0, 2), 1'b1, 8'hBC, 1'b0);
         sum = '0;
         for (int i = 0; i < NB; i++) begin
            d = 8'($urandom);
            r = $urandom_range(0, 63);
            if (r == 0)      send($urandom_range(0, 2), 1'b0, d, 1'b1);
            else if (r == 1) send($urandom_range(0, 2), 1'b1, 8'hBC, 1'b0);
            else if (r == 2) send($urandom_range(0, 2), 1'b1, 8'hF7, 1'b0);
            else begin
               send($urandom_range(0, 2), 1'b0, d, 1'b0);
               sum = sum ^ d;
            end
         end
         r = $urandom_range(0, 7);
         if (r == 0)      send($urandom_range(0, 2), 1'b0, sum ^ 8'h01, 1'b0);
         else if (r == 1) send($urandom_range(0, 2), 1'b1, 8'hBC, 1'b0);
         else             send($urandom_range(0, 2), 1'b0, sum, 1'b0);
      end

      idle(30);
      while (expq.size() > 0) begin
         ev_t ev;
         ev = expq.pop_front();
         checks++;
         errors++;
         $display("FAIL pending_event cycle %0d: got no pulse, expected %s", ev.at,
                  ev.is_err ? "error pulse" : "frame tick");
      end
      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
